// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue controller that walks each instruction through
// FETCH -> DECODE -> EXECUTE -> WRITEBACK around an external combinational ALU.
// It owns an 8 x 32-bit register file and a 16-bit program counter.
// Optional build macro: R0_ZERO_EN makes register 0 a hard-wired zero.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready is high only in FETCH. instr and
// instr_valid are don't-care in every other state. The transfer does not
// depend on instr_ready being registered; it is decoded from the state.
module alu_issue_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic [31:0] alu_ip_0,
   output logic [31:0] alu_ip_1,
   output logic [2:0]  alu_opcode,
   input  logic [31:0] alu_op_0,
   input  logic        alu_change_pc,
   output logic [15:0] pc,
   output logic        retire,
   input  logic [2:0]  dbg_addr,
   output logic [31:0] dbg_data,
   output logic [1:0]  dbgState
);

   typedef enum logic [1:0] {
      FETCH     = 2'd0,
      DECODE    = 2'd1,
      EXECUTE   = 2'd2,
      WRITEBACK = 2'd3
   } stateT;

   stateT       state;
   stateT       nextState;
   logic [31:0] instrQ;
   logic [31:0] opA;
   logic [31:0] opB;
   logic [31:0] resultQ;
   logic        changePcQ;
   logic [31:0] regFile [8];

   // Field views of the latched instruction word.
   logic [2:0]  fOpcode;
   logic [2:0]  fRd;
   logic [2:0]  fRs1;
   logic [2:0]  fRs2;
   logic        fUseImm;
   logic [15:0] fImm;
   logic        wrEn;

   assign fOpcode = instrQ[31:29];
   assign fRd     = instrQ[28:26];
   assign fRs1    = instrQ[25:23];
   assign fRs2    = instrQ[22:20];
   assign fUseImm = instrQ[19];
   assign fImm    = instrQ[15:0];

`ifdef R0_ZERO_EN
   // Writes aimed at register 0 are dropped so it always stays zero.
   assign wrEn = (fRd != 3'd0);
`else
   assign wrEn = 1'b1;
`endif

   assign dbgState = state;

   // State register; reset aborts any in-flight instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH;
      end else begin
         state <= nextState;
      end
   end

   // Next-state sequencing and state-decoded outputs.
   always_comb begin
      nextState   = state;
      instr_ready = 1'b0;
      retire      = 1'b0;
      alu_ip_0    = 32'd0;
      alu_ip_1    = 32'd0;
      alu_opcode  = 3'd0;
      case (state)
         FETCH: begin
            instr_ready = 1'b1;
            if (instr_valid) nextState = DECODE;
         end
         DECODE: begin
            nextState = EXECUTE;
         end
         EXECUTE: begin
            alu_ip_0   = opA;
            alu_ip_1   = opB;
            alu_opcode = fOpcode;
            nextState  = WRITEBACK;
         end
         WRITEBACK: begin
            retire    = 1'b1;
            nextState = FETCH;
         end
         default: nextState = FETCH;
      endcase
   end

   // Datapath: latch instruction, read operands, capture ALU result, commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instrQ    <= 32'd0;
         opA       <= 32'd0;
         opB       <= 32'd0;
         resultQ   <= 32'd0;
         changePcQ <= 1'b0;
         pc        <= 16'd0;
         for (int i = 0; i < 8; i++) regFile[i] <= 32'd0;
      end else begin
         case (state)
            FETCH: begin
               if (instr_valid) instrQ <= instr;
            end
            DECODE: begin
               opA <= regFile[fRs1];
               opB <= fUseImm ? {16'd0, fImm} : regFile[fRs2];
            end
            EXECUTE: begin
               resultQ   <= alu_op_0;
               changePcQ <= alu_change_pc;
            end
            WRITEBACK: begin
               if (wrEn) regFile[fRd] <= resultQ;
               // pc + 1 wraps naturally at 16 bits.
               pc <= changePcQ ? fImm : pc + 16'd1;
            end
            default: ;
         endcase
      end
   end

   // Debug read port; register 0 reads as zero when hard-wired.
   always_comb begin
`ifdef R0_ZERO_EN
      dbg_data = (dbg_addr == 3'd0) ? 32'd0 : regFile[dbg_addr];
`else
      dbg_data = regFile[dbg_addr];
`endif
   end

endmodule
